// File: rtl/matmul_seq_if.sv
// matmul_seq_if: load, array and result signals of the matrix-vector sequencer
interface matmul_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAC_COUNT  = 8
);
  localparam int N  = MAC_COUNT;
  localparam int AW = $clog2(N * N);
  localparam int IW = $clog2(N);
  localparam int RW = 3 * DATA_WIDTH;
  logic                           ld_valid;
  logic                           ld_sel;
  logic [AW-1:0]                  ld_addr;
  logic [DATA_WIDTH-1:0]          ld_data;
  logic                           go;
  logic                           busy;
  logic                           mm_clr;
  logic                           mm_start;
  logic                           mm_stop;
  logic [N-1:0][DATA_WIDTH-1:0]   mm_a;
  logic [DATA_WIDTH-1:0]          mm_b;
  logic [N-1:0][RW-1:0]           mm_c;
  logic                           mm_done;
  logic                           res_valid;
  logic                           res_ready;
  logic [RW-1:0]                  res_data;
  logic [IW-1:0]                  res_idx;
  logic                           res_last;
  modport slave (
    input  ld_valid, ld_sel, ld_addr, ld_data, go, mm_c, mm_done, res_ready,
    output busy, mm_clr, mm_start, mm_stop, mm_a, mm_b, res_valid, res_data, res_idx, res_last
  );
  modport master (
    output ld_valid, ld_sel, ld_addr, ld_data, go, mm_c, mm_done, res_ready,
    input  busy, mm_clr, mm_start, mm_stop, mm_a, mm_b, res_valid, res_data, res_idx, res_last
  );
endinterface

// File: rtl/matmul_seq.sv
// matmul_seq: loads A/B, streams them skewed into the MAC array, collects and drains results
module matmul_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int MAC_COUNT  = 8,
  parameter int A_OFS      = 1
) (
  input logic         clk,
  input logic         rst_n,
  matmul_seq_if.slave bus
);
  localparam int N  = MAC_COUNT;
  localparam int AW = $clog2(N * N);
  localparam int IW = $clog2(N);
  localparam int RW = 3 * DATA_WIDTH;
  localparam int L  = 2 * N - 1 + A_OFS;
  localparam int TW = $clog2(L + 1);
  typedef enum logic [2:0] {IDLE, CLR, START, STREAM, STOP, WAIT_DONE, DRAIN} state_t;
  state_t                       r_st, w_st;
  logic [TW-1:0]                r_t, w_t;
  logic [IW-1:0]                r_idx, w_idx;
  logic [DATA_WIDTH-1:0]        r_a [N*N];
  logic [DATA_WIDTH-1:0]        r_b [N];
  logic [RW-1:0]                r_buf [N];
  logic                         r_busy, r_clr, r_start, r_stop, r_valid, r_last;
  logic                         w_busy, w_clr, w_start, w_stop, w_valid, w_last;
  logic [N-1:0][DATA_WIDTH-1:0] r_mm_a, w_a;
  logic [DATA_WIDTH-1:0]        r_mm_b, w_b;
  logic [RW-1:0]                r_data, w_data;
  int                           w_k;
  always_ff @(posedge clk) begin
    if (r_st == IDLE && bus.ld_valid) begin
      if (bus.ld_sel) r_b[bus.ld_addr[IW-1:0]] <= bus.ld_data;
      else r_a[bus.ld_addr] <= bus.ld_data;
    end
    if (r_st == WAIT_DONE && bus.mm_done)
      for (int i = 0; i < N; i++) r_buf[i] <= bus.mm_c[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st    <= IDLE;
      r_t     <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_clr   <= 1'b0;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_mm_a  <= '0;
      r_mm_b  <= '0;
      r_data  <= '0;
    end else begin
      r_st    <= w_st;
      r_t     <= w_t;
      r_idx   <= w_idx;
      r_busy  <= w_busy;
      r_clr   <= w_clr;
      r_start <= w_start;
      r_stop  <= w_stop;
      r_valid <= w_valid;
      r_last  <= w_last;
      r_mm_a  <= w_a;
      r_mm_b  <= w_b;
      r_data  <= w_data;
    end
  end
  always_comb begin
    w_st  = r_st;
    w_t   = '0;
    w_idx = r_idx;
    case (r_st)
      IDLE: begin
        w_idx = '0;
        if (bus.go) w_st = CLR;
      end
      CLR:   w_st = START;
      START: w_st = STREAM;
      STREAM: begin
        w_t = r_t + 1'b1;
        if (r_t == TW'(L - 1)) begin
          w_st = STOP;
          w_t  = '0;
        end
      end
      STOP: w_st = WAIT_DONE;
      WAIT_DONE: begin
        w_idx = '0;
        if (bus.mm_done) w_st = DRAIN;
      end
      DRAIN: if (bus.res_ready) begin
        w_idx = r_idx + 1'b1;
        if (r_idx == IW'(N - 1)) w_st = IDLE;
      end
      default: w_st = IDLE;
    endcase
  end
  // Outputs are computed from the next state so they can be registered without a cycle of lag.
  always_comb begin
    w_busy  = w_st != IDLE;
    w_clr   = w_st == CLR;
    w_start = w_st == START;
    w_stop  = w_st == STOP;
    w_valid = w_st == DRAIN;
    w_last  = w_valid && w_idx == IW'(N - 1);
    w_b     = (w_st == STREAM && w_t < TW'(N)) ? r_b[w_t[IW-1:0]] : '0;
    w_data  = !w_valid ? '0 : (r_st == WAIT_DONE) ? bus.mm_c[w_idx] : r_buf[w_idx];
    w_a     = '0;
    w_k     = 0;
    for (int i = 0; i < N; i++) begin
      w_k    = int'(w_t) - i - A_OFS;
      w_a[i] = (w_st == STREAM && w_k >= 0 && w_k < N) ? r_a[AW'(i * N + w_k)] : '0;
    end
  end
  assign bus.busy      = r_busy;
  assign bus.mm_clr    = r_clr;
  assign bus.mm_start  = r_start;
  assign bus.mm_stop   = r_stop;
  assign bus.mm_a      = r_mm_a;
  assign bus.mm_b      = r_mm_b;
  assign bus.res_valid = r_valid;
  assign bus.res_data  = r_data;
  assign bus.res_idx   = r_idx;
  assign bus.res_last  = r_last;
endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: scoreboard bench with a behavioural MAC array model driving mm_c/mm_done
module tb_matmul_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  matmul_seq_if #(.DATA_WIDTH(8), .MAC_COUNT(8)) bus ();
  matmul_seq #(.DATA_WIDTH(8), .MAC_COUNT(8), .A_OFS(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {logic [23:0] d; logic [2:0] i; logic l;} exp_t;
  exp_t q[$];
  int pass = 0, total = 0;
  int n_clr = 0, n_start = 0, n_stop = 0;
  int rmode = 0, stall_on = 0, stall_n = 0;
  logic [23:0] acc [8];
  logic [7:0]  b_sr [8];
  int          done_cnt;
  logic        stalled = 1'b0;
  logic [2:0]  p_idx;
  logic [23:0] p_data;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ld(input logic sel, input int addr, input int data);
    bus.ld_valid = 1'b1;
    bus.ld_sel   = sel;
    bus.ld_addr  = addr[5:0];
    bus.ld_data  = data[7:0];
    tick();
    bus.ld_valid = 1'b0;
  endtask
  task automatic start;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
  endtask
  task automatic push(input int i, input int d);
    q.push_back('{d: d[23:0], i: i[2:0], l: (i == 7)});
  endtask
  task automatic run_wait(input string nm);
    int n = 0;
    while ((bus.busy || q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, 64'(n < 3000), 64'd1);
    chk({nm, "_sb_empty"}, 64'(q.size()), 64'd0);
  endtask
  // Array model: lane i sees B delayed by i+1 cycles (input register plus systolic shift).
  always @(posedge clk) begin
    if (!rst_n || bus.mm_clr) begin
      for (int i = 0; i < 8; i++) begin
        acc[i]  <= '0;
        b_sr[i] <= '0;
      end
      done_cnt    <= 0;
      bus.mm_done <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) acc[i] <= acc[i] + 24'(bus.mm_a[i]) * 24'(b_sr[i]);
      b_sr[0] <= bus.mm_b;
      for (int i = 1; i < 8; i++) b_sr[i] <= b_sr[i-1];
      if (bus.mm_stop) done_cnt <= 1;
      else if (done_cnt != 0 && done_cnt < 3) done_cnt <= done_cnt + 1;
      if (done_cnt == 3) bus.mm_done <= 1'b1;
    end
  end
  always_comb for (int i = 0; i < 8; i++) bus.mm_c[i] = acc[i];
  always @(negedge clk) begin
    if (bus.mm_clr) n_clr++;
    if (bus.mm_start) n_start++;
    if (bus.mm_stop) n_stop++;
  end
  always @(negedge clk) begin
    exp_t e;
    if (stalled) begin
      chk("stall_valid", 64'(bus.res_valid), 64'd1);
      chk("stall_idx", 64'(bus.res_idx), 64'(p_idx));
      chk("stall_data", 64'(bus.res_data), 64'(p_data));
    end
    if (bus.res_valid && bus.res_ready) begin
      if (q.size() == 0) chk("unexpected_result", 64'(bus.res_idx), 64'hdead);
      else begin
        e = q.pop_front();
        chk("res_data", 64'(bus.res_data), 64'(e.d));
        chk("res_idx", 64'(bus.res_idx), 64'(e.i));
        chk("res_last", 64'(bus.res_last), 64'(e.l));
      end
    end
    stalled = bus.res_valid && !bus.res_ready;
    p_idx   = bus.res_idx;
    p_data  = bus.res_data;
  end
  initial begin
    bus.res_ready = 1'b1;
    forever begin
      tick();
      if (rmode == 0) bus.res_ready = 1'b1;
      else if (stall_on != 0 && bus.res_valid && bus.res_idx == 3'd2 && stall_n < 10) begin
        bus.res_ready = 1'b0;
        stall_n++;
      end else bus.res_ready = 1'($urandom_range(0, 1));
    end
  end
  initial begin
    int c0, s0, p0;
    bus.ld_valid = 1'b0;
    bus.ld_sel   = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    bus.go       = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_pulses", 64'({bus.mm_clr, bus.mm_start, bus.mm_stop}), 64'd0);
    chk("rst_res", 64'({bus.res_valid, bus.res_last, bus.res_idx}), 64'd0);
    chk("rst_mm_a", 64'(bus.mm_a), 64'd0);
    chk("rst_data", 64'({bus.mm_b, bus.res_data}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    // Identity A, B = 1..8
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) ld(1'b0, r * 8 + c, (r == c) ? 1 : 0);
    for (int k = 0; k < 8; k++) ld(1'b1, k, k + 1);
    for (int i = 0; i < 8; i++) push(i, i + 1);
    c0 = n_clr; s0 = n_start; p0 = n_stop;
    start();
    chk("go_busy", 64'(bus.busy), 64'd1);
    run_wait("ident");
    chk("ident_clr_cnt", 64'(n_clr - c0), 64'd1);
    chk("ident_start_cnt", 64'(n_start - s0), 64'd1);
    chk("ident_stop_cnt", 64'(n_stop - p0), 64'd1);
    // Skew: A[i][k] = 16i+k, B[k] = k+1, lane i = 576i + 168
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) ld(1'b0, r * 8 + c, 16 * r + c);
    for (int k = 0; k < 8; k++) ld(1'b1, k, k + 1);
    for (int i = 0; i < 8; i++) push(i, 576 * i + 168);
    start();
    for (int c = 1; c <= 19; c++) begin
      if (c == 1) chk("skew_clr", 64'(bus.mm_clr), 64'd1);
      if (c == 2) chk("skew_start", 64'(bus.mm_start), 64'd1);
      if (c >= 3 && c <= 18) begin
        chk("skew_mm_b", 64'(bus.mm_b), 64'((c - 3 < 8) ? c - 2 : 0));
        chk("skew_mm_a3", 64'(bus.mm_a[3]), 64'((c - 7 >= 0 && c - 7 < 8) ? 48 + c - 7 : 0));
      end
      if (c == 19) chk("skew_stop", 64'(bus.mm_stop), 64'd1);
      tick();
    end
    run_wait("skew");
    // All 255 with random ready and a 10-cycle stall at idx 2
    for (int a = 0; a < 64; a++) ld(1'b0, a, 255);
    for (int k = 0; k < 8; k++) ld(1'b1, k, 255);
    for (int i = 0; i < 8; i++) push(i, 520200);
    rmode = 1; stall_on = 1;
    start();
    run_wait("max_stall");
    chk("stall_cycles", 64'(stall_n), 64'd10);
    rmode = 0; stall_on = 0;
    // go and ld_valid during STREAM are ignored
    for (int i = 0; i < 8; i++) push(i, 520200);
    start();
    repeat (5) tick();
    for (int j = 0; j < 4; j++) begin
      bus.go = 1'b1;
      ld(j[0], 0, 0);
    end
    bus.go = 1'b0;
    run_wait("busy_ignore");
    // Write in the same IDLE cycle as go takes effect in this run
    push(0, 455175);
    for (int i = 1; i < 8; i++) push(i, 520200);
    bus.go = 1'b1;
    ld(1'b0, 0, 0);
    bus.go = 1'b0;
    run_wait("go_with_ld");
    // Reset at STREAM t=5, then rerun from stored A/B
    p0 = n_stop;
    start();
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_mm_a", 64'(bus.mm_a), 64'd0);
    chk("midrst_outs", 64'({bus.mm_b, bus.mm_clr, bus.mm_start, bus.mm_stop, bus.res_valid}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (25) tick();
    chk("midrst_no_stop", 64'(n_stop - p0), 64'd0);
    chk("midrst_idle", 64'(bus.busy), 64'd0);
    push(0, 455175);
    for (int i = 1; i < 8; i++) push(i, 520200);
    start();
    run_wait("rerun");
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
